// File: rtl/mem_access_arbiter_if.sv
// Bus bundle for mem_access_arbiter: fetch and data requester handshakes
// plus the shared MAIN_MEMORY RD/WR/ACK port.
// slave  : arbiter side
// master : requester/memory side (testbench or surrounding glue)
interface mem_access_arbiter_if #(
  parameter int DATAWIDTH_BUS = 32
);
  logic                     MEM_ARB_F_REQ;
  logic [DATAWIDTH_BUS-1:0] MEM_ARB_F_ADDR;
  logic                     MEM_ARB_F_DONE;
  logic                     MEM_ARB_D_REQ;
  logic                     MEM_ARB_D_WE;
  logic [DATAWIDTH_BUS-1:0] MEM_ARB_D_ADDR;
  logic [DATAWIDTH_BUS-1:0] MEM_ARB_D_WDATA;
  logic                     MEM_ARB_D_DONE;
  logic [DATAWIDTH_BUS-1:0] MEM_ARB_RDATA_OutBUS;
  logic                     MEM_ARB_ERROR;
  logic                     MEM_ARB_GNT;
  logic                     MEM_ARB_BUSY;
  logic                     MEM_ARB_MEM_RD;
  logic                     MEM_ARB_MEM_WR;
  logic [DATAWIDTH_BUS-1:0] MEM_ARB_MEM_ADDR;
  logic [DATAWIDTH_BUS-1:0] MEM_ARB_MEM_WDATA;
  logic [DATAWIDTH_BUS-1:0] MEM_ARB_MEM_RDATA_InBUS;
  logic                     MEM_ARB_MEM_ACK;

  modport slave (
    input  MEM_ARB_F_REQ, MEM_ARB_F_ADDR,
    input  MEM_ARB_D_REQ, MEM_ARB_D_WE, MEM_ARB_D_ADDR, MEM_ARB_D_WDATA,
    input  MEM_ARB_MEM_RDATA_InBUS, MEM_ARB_MEM_ACK,
    output MEM_ARB_F_DONE, MEM_ARB_D_DONE, MEM_ARB_RDATA_OutBUS,
    output MEM_ARB_ERROR, MEM_ARB_GNT, MEM_ARB_BUSY,
    output MEM_ARB_MEM_RD, MEM_ARB_MEM_WR, MEM_ARB_MEM_ADDR, MEM_ARB_MEM_WDATA
  );

  modport master (
    output MEM_ARB_F_REQ, MEM_ARB_F_ADDR,
    output MEM_ARB_D_REQ, MEM_ARB_D_WE, MEM_ARB_D_ADDR, MEM_ARB_D_WDATA,
    output MEM_ARB_MEM_RDATA_InBUS, MEM_ARB_MEM_ACK,
    input  MEM_ARB_F_DONE, MEM_ARB_D_DONE, MEM_ARB_RDATA_OutBUS,
    input  MEM_ARB_ERROR, MEM_ARB_GNT, MEM_ARB_BUSY,
    input  MEM_ARB_MEM_RD, MEM_ARB_MEM_WR, MEM_ARB_MEM_ADDR, MEM_ARB_MEM_WDATA
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one MAIN_MEMORY RD/WR/ACK port between the
// instruction-fetch requester (read-only) and the datapath load/store
// requester. One request is latched at a time, the memory strobe is held
// until ACK or watchdog expiry, then a one-cycle DONE goes to the granted side.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: alternate grants under
// contention; without it the data port always wins a tie.
module mem_access_arbiter #(
  parameter int DATAWIDTH_BUS     = 32,
  parameter int TIMEOUT_CYCLES    = 255,
  parameter int DATAWIDTH_TIMEOUT = 16
) (
  input  logic                      MEM_ARB_CLOCK_50,
  input  logic                      MEM_ARB_RESET_InLow,
  mem_access_arbiter_if.slave       bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_RELEASE} state_t;

  localparam logic [DATAWIDTH_TIMEOUT-1:0] WD_LAST = DATAWIDTH_TIMEOUT'(TIMEOUT_CYCLES - 1);
  localparam logic [DATAWIDTH_TIMEOUT-1:0] WD_ONE  = DATAWIDTH_TIMEOUT'(1);

  state_t                       r_state;
  logic                         r_armed;   // request latched, strobe goes out next edge
  logic                         r_we;
  logic                         r_gnt;
  logic                         r_rd;
  logic                         r_wr;
  logic [DATAWIDTH_BUS-1:0]     r_addr;
  logic [DATAWIDTH_BUS-1:0]     r_wdata;
  logic [DATAWIDTH_BUS-1:0]     r_rdata;
  logic                         r_f_done;
  logic                         r_d_done;
  logic                         r_error;
  logic                         r_busy;
  logic [DATAWIDTH_TIMEOUT-1:0] r_wdog;

  logic w_any_req;
  logic w_pick_d;
  logic w_wd_last;

  assign w_any_req = bus.MEM_ARB_F_REQ | bus.MEM_ARB_D_REQ;
  assign w_wd_last = (r_wdog == WD_LAST);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last served side: 0 = fetch, 1 = data
  logic r_last;

  // On a tie the side that was not served last wins
  assign w_pick_d = bus.MEM_ARB_D_REQ & (~bus.MEM_ARB_F_REQ | ~r_last);

  // Remember who got the most recent grant
  always_ff @(posedge MEM_ARB_CLOCK_50 or negedge MEM_ARB_RESET_InLow) begin
    if (!MEM_ARB_RESET_InLow)                      r_last <= 1'b0;
    else if (r_state == S_IDLE && !r_armed && w_any_req) r_last <= w_pick_d;
  end
`else
  // Fixed priority: data beats fetch (fetch can starve under steady data load)
  assign w_pick_d = bus.MEM_ARB_D_REQ;
`endif

  // Main sequencer: latch, strobe, respond, wait out a lingering ACK
  always_ff @(posedge MEM_ARB_CLOCK_50 or negedge MEM_ARB_RESET_InLow) begin
    if (!MEM_ARB_RESET_InLow) begin
      r_state  <= S_IDLE;
      r_armed  <= 1'b0;
      r_we     <= 1'b0;
      r_gnt    <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_f_done <= 1'b0;
      r_d_done <= 1'b0;
      r_error  <= 1'b0;
      r_busy   <= 1'b0;
      r_wdog   <= '0;
    end else begin
      r_f_done <= 1'b0;
      r_d_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_armed) begin
            r_armed <= 1'b0;
            r_rd    <= ~r_we;
            r_wr    <= r_we;
            r_state <= S_ACCESS;
            r_busy  <= 1'b1;
          end else if (w_any_req) begin
            r_armed <= 1'b1;
            r_gnt   <= w_pick_d;
            r_we    <= w_pick_d & bus.MEM_ARB_D_WE;
            r_addr  <= w_pick_d ? bus.MEM_ARB_D_ADDR : bus.MEM_ARB_F_ADDR;
            r_wdata <= w_pick_d ? bus.MEM_ARB_D_WDATA : '0;
            r_wdog  <= '0;
          end
        end
        S_ACCESS: begin
          r_wdog <= r_wdog + WD_ONE;
          // ACK beats an expiring watchdog in the same cycle
          if (bus.MEM_ARB_MEM_ACK || w_wd_last) begin
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_f_done <= ~r_gnt;
            r_d_done <= r_gnt;
            r_error  <= ~bus.MEM_ARB_MEM_ACK;
            r_state  <= S_RESP;
            if (bus.MEM_ARB_MEM_ACK && !r_we) r_rdata <= bus.MEM_ARB_MEM_RDATA_InBUS;
          end
        end
        S_RESP: begin
          r_error <= 1'b0;
          if (bus.MEM_ARB_MEM_ACK) begin
            r_state <= S_RELEASE;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_RELEASE: begin
          // a still-high ACK must not complete the next access
          if (!bus.MEM_ARB_MEM_ACK) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MEM_ARB_F_DONE       = r_f_done;
  assign bus.MEM_ARB_D_DONE       = r_d_done;
  assign bus.MEM_ARB_RDATA_OutBUS = r_rdata;
  assign bus.MEM_ARB_ERROR        = r_error;
  assign bus.MEM_ARB_GNT          = r_gnt;
  assign bus.MEM_ARB_BUSY         = r_busy;
  assign bus.MEM_ARB_MEM_RD       = r_rd;
  assign bus.MEM_ARB_MEM_WR       = r_wr;
  assign bus.MEM_ARB_MEM_ADDR     = r_addr;
  assign bus.MEM_ARB_MEM_WDATA    = r_wdata;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter (TIMEOUT_CYCLES = 4). A memory responder with
// programmable ACK latency / sticky ACK serves the strobe; a transaction-level
// model predicts the winner, strobe length, error and returned data.
module tb_mem_access_arbiter;
  localparam int W = 32;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_arbiter_if #(.DATAWIDTH_BUS(W)) bus ();

  mem_access_arbiter #(.DATAWIDTH_BUS(W), .TIMEOUT_CYCLES(T), .DATAWIDTH_TIMEOUT(16)) dut (
    .MEM_ARB_CLOCK_50    (clk),
    .MEM_ARB_RESET_InLow (rst_n),
    .bus                 (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // memory responder knobs
  int          mem_lat = 0;   // strobe cycles before ACK (large = never)
  int          sticky  = 0;   // extra cycles ACK lingers after the strobe drops
  int          m_cnt   = 0;
  int          m_hold  = 0;
  logic [W-1:0] mem_word = '0;

  // reference model state
  bit           m_last  = 1'b0;   // last served: 0 fetch, 1 data
  logic [W-1:0] m_rdata = '0;

  assign bus.MEM_ARB_MEM_RDATA_InBUS = mem_word;

  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      bus.MEM_ARB_MEM_ACK = 1'b0;
      m_cnt = 0;
      m_hold = 0;
    end else if (bus.MEM_ARB_MEM_RD || bus.MEM_ARB_MEM_WR) begin
      if (m_cnt >= mem_lat) begin
        bus.MEM_ARB_MEM_ACK = 1'b1;
        m_hold = sticky;
      end
      m_cnt++;
    end else begin
      m_cnt = 0;
      if (m_hold > 0) m_hold--;
      else bus.MEM_ARB_MEM_ACK = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive requests and check every grant. we_mode: 0 read, 1 write, 2 random.
  task automatic run(input int nf, input int nd, input int we_mode, input bit rnd);
    int f_left = nf;
    int d_left = nd;
    int scnt = 0, e_cnt = 0, cyc = 0;
    bit in_txn = 0, win_d = 0, e_we = 0, e_err = 0, chk_idle = 0, stale = 0;
    bit p1f = 0, p1d = 0, p2f = 0, p2d = 0, strobe, just_done;
    logic [W-1:0] e_addr = '0, e_wdata = '0, e_rdata = '0;
    while (1) begin
      @(negedge clk);
      cyc++;
      just_done = 0;
      if (cyc > 3000) begin
        chk("cycle_budget", W'(cyc), W'(3000));
        break;
      end
      strobe = bus.MEM_ARB_MEM_RD | bus.MEM_ARB_MEM_WR;
      if (strobe && !in_txn) begin
        chk("stale_ack_grant", W'(stale), W'(0));
        chk("grant_has_req", W'(p2f | p2d), W'(1));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win_d = (p2f && p2d) ? !m_last : p2d;
`else
        win_d = p2d;
`endif
        m_last = win_d;
        e_we    = win_d & bus.MEM_ARB_D_WE;
        e_addr  = win_d ? bus.MEM_ARB_D_ADDR : bus.MEM_ARB_F_ADDR;
        e_wdata = bus.MEM_ARB_D_WDATA;
        if (rnd) mem_word = $urandom;
        e_err   = (mem_lat > T - 1);
        e_cnt   = e_err ? T : mem_lat + 1;
        e_rdata = (!e_we && !e_err) ? mem_word : m_rdata;
        in_txn = 1;
        scnt = 0;
      end
      if (strobe) begin
        scnt++;
        chk("mem_rd", W'(bus.MEM_ARB_MEM_RD), W'(!e_we));
        chk("mem_wr", W'(bus.MEM_ARB_MEM_WR), W'(e_we));
        chk("mem_addr", bus.MEM_ARB_MEM_ADDR, e_addr);
        if (win_d) chk("mem_wdata", bus.MEM_ARB_MEM_WDATA, e_wdata);
      end
      if (bus.MEM_ARB_F_DONE || bus.MEM_ARB_D_DONE) begin
        chk("done_in_txn", W'(in_txn), W'(1));
        chk("f_done", W'(bus.MEM_ARB_F_DONE), W'(!win_d));
        chk("d_done", W'(bus.MEM_ARB_D_DONE), W'(win_d));
        chk("error", W'(bus.MEM_ARB_ERROR), W'(e_err));
        chk("rdata", bus.MEM_ARB_RDATA_OutBUS, e_rdata);
        chk("gnt", W'(bus.MEM_ARB_GNT), W'(win_d));
        chk("strobe_cycles", W'(scnt), W'(e_cnt));
        chk("strobe_off_at_done", W'(strobe), W'(0));
        m_rdata = e_rdata;
        in_txn = 0;
        if (win_d) begin bus.MEM_ARB_D_REQ = 1'b0; d_left--; end
        else       begin bus.MEM_ARB_F_REQ = 1'b0; f_left--; end
        chk_idle = (sticky == 0);
        just_done = 1;
      end else begin
        if (chk_idle) begin
          chk("busy_after_done", W'(bus.MEM_ARB_BUSY), W'(0));
          chk("error_cleared", W'(bus.MEM_ARB_ERROR), W'(0));
          chk_idle = 0;
        end
        if (!in_txn && bus.MEM_ARB_MEM_ACK) chk("busy_stale_ack", W'(bus.MEM_ARB_BUSY), W'(1));
      end
      stale = !in_txn && bus.MEM_ARB_MEM_ACK;
      if (!just_done) begin
        if (!bus.MEM_ARB_F_REQ && f_left > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
          if (rnd) bus.MEM_ARB_F_ADDR = $urandom;
          bus.MEM_ARB_F_REQ = 1'b1;
        end
        if (!bus.MEM_ARB_D_REQ && d_left > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
          if (rnd) begin
            bus.MEM_ARB_D_ADDR  = $urandom;
            bus.MEM_ARB_D_WDATA = $urandom;
          end
          bus.MEM_ARB_D_WE  = (we_mode == 2) ? 1'($urandom_range(0, 1)) : (we_mode == 1);
          bus.MEM_ARB_D_REQ = 1'b1;
        end
      end
      p2f = p1f; p2d = p1d;
      p1f = bus.MEM_ARB_F_REQ; p1d = bus.MEM_ARB_D_REQ;
      if (f_left == 0 && d_left == 0 && !in_txn && !chk_idle &&
          !bus.MEM_ARB_BUSY && !bus.MEM_ARB_MEM_ACK) break;
    end
  endtask

  initial begin
    int wait_cyc;
    bus.MEM_ARB_F_REQ = 0; bus.MEM_ARB_F_ADDR = '0;
    bus.MEM_ARB_D_REQ = 0; bus.MEM_ARB_D_WE = 0;
    bus.MEM_ARB_D_ADDR = '0; bus.MEM_ARB_D_WDATA = '0;
    bus.MEM_ARB_MEM_ACK = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rd", W'(bus.MEM_ARB_MEM_RD), W'(0));
    chk("rst_wr", W'(bus.MEM_ARB_MEM_WR), W'(0));
    chk("rst_addr", bus.MEM_ARB_MEM_ADDR, '0);
    chk("rst_wdata", bus.MEM_ARB_MEM_WDATA, '0);
    chk("rst_rdata", bus.MEM_ARB_RDATA_OutBUS, '0);
    chk("rst_done", W'({bus.MEM_ARB_F_DONE, bus.MEM_ARB_D_DONE}), W'(0));
    chk("rst_err_gnt_busy", W'({bus.MEM_ARB_ERROR, bus.MEM_ARB_GNT, bus.MEM_ARB_BUSY}), W'(0));
    rst_n = 1'b1;

    // fetch read, ACK on the second strobe cycle
    mem_lat = 1; sticky = 0; mem_word = 32'hCAFE0001;
    bus.MEM_ARB_F_ADDR = 32'h0000_0010;
    run(1, 0, 0, 0);
    chk("fetch_rdata", bus.MEM_ARB_RDATA_OutBUS, 32'hCAFE0001);

    // data write, ACK on the first strobe cycle; RDATA untouched
    mem_lat = 0; mem_word = 32'hDEAD_BEEF;
    bus.MEM_ARB_D_ADDR = 32'h20; bus.MEM_ARB_D_WDATA = 32'h12345678;
    run(0, 1, 1, 0);
    chk("write_keeps_rdata", bus.MEM_ARB_RDATA_OutBUS, 32'hCAFE0001);

    // timeout with no ACK, then ACK landing on the last allowed cycle
    mem_lat = 1000; run(0, 1, 0, 0);
    mem_lat = T - 1; mem_word = 32'h0BAD_F00D; run(0, 1, 0, 0);

    // contention, both requesters three transactions each
    mem_lat = 1; run(3, 3, 2, 1);

    // sticky ACK with the other requester waiting
    mem_lat = 1; sticky = 3; run(1, 1, 0, 1);
    sticky = 0;

    // randomized rounds, including latencies past the watchdog
    for (int r = 0; r < 6; r++) begin
      mem_lat = $urandom_range(0, T + 1);
      sticky  = $urandom_range(0, 2);
      run($urandom_range(1, 4), $urandom_range(1, 4), 2, 1);
    end
    sticky = 0;

    // reset in the middle of an access
    mem_lat = 1000;
    bus.MEM_ARB_D_ADDR = 32'h44; bus.MEM_ARB_D_WE = 0; bus.MEM_ARB_D_REQ = 1;
    wait_cyc = 0;
    while (!bus.MEM_ARB_MEM_RD && wait_cyc < 20) begin @(negedge clk); wait_cyc++; end
    chk("pre_reset_rd", W'(bus.MEM_ARB_MEM_RD), W'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", W'(bus.MEM_ARB_MEM_RD), W'(0));
    chk("mid_rst_busy", W'(bus.MEM_ARB_BUSY), W'(0));
    chk("mid_rst_gnt", W'(bus.MEM_ARB_GNT), W'(0));
    chk("mid_rst_rdata", bus.MEM_ARB_RDATA_OutBUS, '0);
    chk("mid_rst_done", W'({bus.MEM_ARB_F_DONE, bus.MEM_ARB_D_DONE}), W'(0));
    bus.MEM_ARB_D_REQ = 0;
    m_last = 1'b0; m_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // re-issued request after reset
    mem_lat = 2; mem_word = 32'h5A5A_0001;
    run(0, 1, 0, 0);
    chk("reissue_rdata", bus.MEM_ARB_RDATA_OutBUS, 32'h5A5A_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
